neuron_block: RTL and testbench

NEURON_BLOCK -- requirements
Module: neuron_block

---
 rtl/snn_pkg.sv | 19 +
 rtl/sat_add.sv | 30 +++
 rtl/neuron_block.sv | 135 +++++++++++++
 tb/tb_neuron_block.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared defaults, FSM state codes and reset-mode encodings for the neuron block
package snn_pkg;

    localparam int DEF_NUM_AXONS       = 256;
    localparam int DEF_FIELD_WIDTH     = 9;
    localparam int DEF_NUM_RESET_MODES = 2;

    localparam int RESET_ABSOLUTE = 0;
    localparam int RESET_LINEAR   = 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_INTEGRATE = 3'd1;
    localparam state_t ST_LEAK      = 3'd2;
    localparam state_t ST_FIRE      = 3'd3;
    localparam state_t ST_DONE      = 3'd4;

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational signed add/subtract, one bit wider internally, clamped to WIDTH
module sat_add #(
    parameter int WIDTH = 9
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic                    sub,
    output logic signed [WIDTH-1:0] sum
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0] wide;

    always_comb begin
        if (sub) begin
            wide = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        end else begin
            wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        end
        // Top two bits disagree only when the true result left the WIDTH-bit range
        if (wide[WIDTH] != wide[WIDTH-1]) begin
            sum = wide[WIDTH] ? MIN_VAL : MAX_VAL;
        end else begin
            sum = wide[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/neuron_block.sv
// rtl/neuron_block.sv - sequential leaky integrate-and-fire update, one axon per clock
module neuron_block
    import snn_pkg::*;
#(
    parameter int NUM_AXONS       = DEF_NUM_AXONS,
    parameter int WEIGHT_WIDTH    = DEF_FIELD_WIDTH,
    parameter int LEAK_WIDTH      = DEF_FIELD_WIDTH,
    parameter int THRESHOLD_WIDTH = DEF_FIELD_WIDTH,
    parameter int POTENTIAL_WIDTH = DEF_FIELD_WIDTH,
    parameter int NUM_RESET_MODES = DEF_NUM_RESET_MODES
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_ni,
    input  logic                                 enable_calc_i,
    input  logic [NUM_AXONS-1:0]                 axon_spikes_i,
    input  logic [NUM_AXONS-1:0]                 connections_i,
    input  logic signed [LEAK_WIDTH-1:0]         leak_i,
    input  logic signed [WEIGHT_WIDTH-1:0]       weights_0_i,
    input  logic signed [WEIGHT_WIDTH-1:0]       weights_1_i,
    input  logic signed [THRESHOLD_WIDTH-1:0]    positive_threshold_i,
    input  logic signed [THRESHOLD_WIDTH-1:0]    negative_threshold_i,
    input  logic signed [POTENTIAL_WIDTH-1:0]    reset_potential_i,
    input  logic signed [POTENTIAL_WIDTH-1:0]    current_potential_i,
    input  logic [$clog2(NUM_RESET_MODES)-1:0]   reset_mode_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 spike_o,
    output logic signed [POTENTIAL_WIDTH-1:0]    new_potential_o
);

    localparam int CW = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
    localparam int RW = $clog2(NUM_RESET_MODES);
    localparam int PW = POTENTIAL_WIDTH;

    state_t                       state_q;
    logic [NUM_AXONS-1:0]         active_q;
    logic [CW-1:0]                cnt_q;
    logic signed [PW-1:0]         acc_q;
    logic signed [WEIGHT_WIDTH-1:0]    w0_q, w1_q;
    logic signed [LEAK_WIDTH-1:0]      leak_q;
    logic signed [THRESHOLD_WIDTH-1:0] pthr_q, nthr_q;
    logic signed [PW-1:0]         rpot_q;
    logic [RW-1:0]                mode_q;
    logic                         fired_q;

    logic signed [PW-1:0] weight_ext, leak_ext, pthr_ext, nthr_ext;
    logic signed [PW-1:0] int_sum, leak_sum, lin_sum;

    always_comb begin
        weight_ext = '0;
        if (active_q[cnt_q]) begin
            weight_ext = cnt_q[0] ? PW'(w1_q) : PW'(w0_q);
        end
        leak_ext = PW'(leak_q);
        pthr_ext = PW'(pthr_q);
        nthr_ext = PW'(nthr_q);
    end

    sat_add #(.WIDTH(PW)) u_sat_integrate (.a(acc_q), .b(weight_ext), .sub(1'b0), .sum(int_sum));
    sat_add #(.WIDTH(PW)) u_sat_leak      (.a(acc_q), .b(leak_ext),   .sub(1'b0), .sum(leak_sum));
    sat_add #(.WIDTH(PW)) u_sat_linear    (.a(acc_q), .b(pthr_ext),   .sub(1'b1), .sum(lin_sum));

    assign busy_o = (state_q != ST_IDLE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q         <= ST_IDLE;
            active_q        <= '0;
            cnt_q           <= '0;
            acc_q           <= '0;
            w0_q            <= '0;
            w1_q            <= '0;
            leak_q          <= '0;
            pthr_q          <= '0;
            nthr_q          <= '0;
            rpot_q          <= '0;
            mode_q          <= '0;
            fired_q         <= 1'b0;
            done_o          <= 1'b0;
            spike_o         <= 1'b0;
            new_potential_o <= '0;
        end else begin
            done_o  <= 1'b0;
            spike_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable_calc_i) begin
                        active_q <= axon_spikes_i & connections_i;
                        w0_q     <= weights_0_i;
                        w1_q     <= weights_1_i;
                        leak_q   <= leak_i;
                        pthr_q   <= positive_threshold_i;
                        nthr_q   <= negative_threshold_i;
                        rpot_q   <= reset_potential_i;
                        mode_q   <= reset_mode_i;
                        acc_q    <= current_potential_i;
                        cnt_q    <= '0;
                        state_q  <= ST_INTEGRATE;
                    end
                end
                ST_INTEGRATE: begin
                    acc_q <= int_sum;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(NUM_AXONS - 1)) begin
                        state_q <= ST_LEAK;
                    end
                end
                ST_LEAK: begin
                    acc_q   <= leak_sum;
                    state_q <= ST_FIRE;
                end
                ST_FIRE: begin
                    if (acc_q >= pthr_ext) begin
                        fired_q <= 1'b1;
                        acc_q   <= (mode_q == RW'(RESET_LINEAR)) ? lin_sum : rpot_q;
                    end else begin
                        fired_q <= 1'b0;
                        if (acc_q < nthr_ext) begin
                            acc_q <= nthr_ext;
                        end
                    end
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_o          <= 1'b1;
                    spike_o         <= fired_q;
                    new_potential_o <= acc_q;
                    state_q         <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_block.sv
// tb/tb_neuron_block.sv - scoreboard bench for neuron_block with directed and random updates
module tb_neuron_block;

    localparam int N    = 256;
    localparam int PMIN = -256;
    localparam int PMAX = 255;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                en = 1'b0;
    logic [N-1:0]        spikes = '0;
    logic [N-1:0]        conn = '0;
    logic signed [8:0]   leak = '0, w0 = '0, w1 = '0, pthr = '0, nthr = '0, rpot = '0, cpot = '0;
    logic [0:0]          mode = '0;
    logic                busy, done, spike;
    logic signed [8:0]   newp;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    typedef struct {
        bit     spike;
        int     pot;
        longint cyc;
    } exp_t;
    exp_t sb[$];

    neuron_block #(
        .NUM_AXONS(N), .WEIGHT_WIDTH(9), .LEAK_WIDTH(9), .THRESHOLD_WIDTH(9),
        .POTENTIAL_WIDTH(9), .NUM_RESET_MODES(2)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable_calc_i(en),
        .axon_spikes_i(spikes), .connections_i(conn), .leak_i(leak),
        .weights_0_i(w0), .weights_1_i(w1), .positive_threshold_i(pthr),
        .negative_threshold_i(nthr), .reset_potential_i(rpot),
        .current_potential_i(cpot), .reset_mode_i(mode),
        .busy_o(busy), .done_o(done), .spike_o(spike), .new_potential_o(newp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int v);
        return (v > PMAX) ? PMAX : ((v < PMIN) ? PMIN : v);
    endfunction

    // Behavioural neuron update: walk axons in order, then leak, then threshold rules
    function automatic void model(input logic [N-1:0] sp, input logic [N-1:0] cn,
                                  input int pot, input int a0, input int a1, input int lk,
                                  input int pt, input int nt, input int rp, input int md,
                                  output bit sk, output int p);
        p  = pot;
        sk = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (sp[i] && cn[i]) p = sat(p + ((i % 2 == 1) ? a1 : a0));
        end
        p = sat(p + lk);
        if (p >= pt) begin
            sk = 1'b1;
            p  = (md == 1) ? sat(p - pt) : rp;
        end else if (p < nt) begin
            p = nt;
        end
    endfunction

    task automatic check_int(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [N-1:0] rvec(input int pct);
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    function automatic int rs(input int lo, input int hi);
        return int'($urandom_range(0, hi - lo)) + lo;
    endfunction

    task automatic monitor_step();
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check_int("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check_int("spike", longint'(spike), longint'(e.spike));
                check_int("new_potential", longint'(newp), longint'(e.pot));
                check_int("done_latency", cyc, e.cyc);
            end
        end
    endtask

    task automatic run_case(input logic [N-1:0] sp, input logic [N-1:0] cn,
                            input int pot, input int a0, input int a1, input int lk,
                            input int pt, input int nt, input int rp, input int md,
                            input int abort_after);
        exp_t e;
        int   t;
        int   dones;
        @(negedge clk);
        t = 0;
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (busy) check_int("idle_wait_timeout", 1, 0);
        spikes = sp; conn = cn; cpot = 9'(pot); w0 = 9'(a0); w1 = 9'(a1);
        leak = 9'(lk); pthr = 9'(pt); nthr = 9'(nt); rpot = 9'(rp); mode = 1'(md);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        model(sp, cn, pot, a0, a1, lk, pt, nt, rp, md, e.spike, e.pot);
        e.cyc = cyc + N + 3;
        sb.push_back(e);
        check_int("busy_after_start", longint'(busy), 1);
        if (abort_after > 0) begin
            repeat (abort_after) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_int("abort_busy", longint'(busy), 0);
            check_int("abort_done", longint'(done), 0);
            check_int("abort_spike", longint'(spike), 0);
            check_int("abort_potential", longint'(newp), 0);
            sb.delete();
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            dones = 0;
            repeat (300) begin
                @(negedge clk);
                if (done) dones++;
            end
            check_int("done_after_abort", dones, 0);
        end else begin
            t = 0;
            do begin
                @(negedge clk);
                t++;
                if (done) break;
                if (busy) begin
                    // Inputs and enable wander while the update runs; the result must not move
                    spikes = rvec(50); conn = rvec(50); cpot = 9'(rs(PMIN, PMAX));
                    w0 = 9'(rs(PMIN, PMAX)); w1 = 9'(rs(PMIN, PMAX)); leak = 9'(rs(PMIN, PMAX));
                    pthr = 9'(rs(PMIN, PMAX)); nthr = 9'(rs(PMIN, PMAX)); mode = 1'($urandom_range(0, 1));
                    en = 1'($urandom_range(0, 1));
                end else begin
                    en = 1'b0;
                end
            end while (t < 400);
            en = 1'b0;
            if (!done) check_int("done_timeout", 0, 1);
        end
    endtask

    logic [N-1:0] v_a, v_b;

    initial begin
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        spikes = '1; conn = '1; cpot = 9'sd33; w0 = 9'sd3;
        #2 rst_n = 1'b0;
        #1;
        check_int("reset_busy", longint'(busy), 0);
        check_int("reset_done", longint'(done), 0);
        check_int("reset_spike", longint'(spike), 0);
        check_int("reset_potential", longint'(newp), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        v_a = '0; v_a[0] = 1'b1; v_a[2] = 1'b1; v_a[4] = 1'b1;
        run_case(v_a, v_a, 0, 5, 0, 0, 100, -100, 0, 0, 0);
        v_b = '0; v_b[1] = 1'b1;
        run_case(v_b, v_b, 90, 0, 20, 0, 100, -100, 7, 0, 0);
        run_case(v_b, v_b, 90, 0, 20, 0, 100, -100, 7, 1, 0);
        run_case('1, '1, 250, 9, 9, 0, 255, -100, 0, 0, 0);
        run_case('1, '1, 250, 9, 9, 0, 255, -100, 0, 1, 0);
        run_case('0, '1, -50, 0, 0, -60, 100, -100, 0, 0, 0);
        run_case(v_a, v_a, 0, 5, 0, 0, 100, -100, 0, 0, 100);
        run_case(v_a, v_a, 0, 5, 0, 0, 100, -100, 0, 0, 0);

        for (int k = 0; k < 30; k++) begin
            run_case(rvec(rs(0, 100)), rvec(rs(0, 100)), rs(PMIN, PMAX),
                     rs(-20, 20), rs(-20, 20), rs(-30, 30),
                     rs(-50, PMAX), rs(PMIN, 50), rs(PMIN, PMAX), rs(0, 1), 0);
        end

        repeat (5) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
